// File: rtl/core_sequencer_if.sv
// Memory-side handshake bundle for core_sequencer: the instruction fetch channel
// and the data-memory strobes and completion.
`timescale 1ns/1ps
interface core_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_ready;
  logic        mem_read_en;
  logic        mem_write_en;

  modport master (
    output imem_req, mem_read_en, mem_write_en,
    input  imem_ack, imem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, mem_read_en, mem_write_en,
    output imem_ack, imem_rdata, dmem_ready
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV32 control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// a terminal TRAP on illegal opcodes. Every strobe is registered from the next state.
`timescale 1ns/1ps
module core_sequencer #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  core_sequencer_if.master    bus,
  input  logic                branch_taken,
  output logic [WIDTH-1:0]    pc,
  output logic [6:0]          opcode,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd,
  output logic [11:0]         imm_reg,
  output logic [4:0]          shamt,
  output logic                reg_write_en,
  output logic                instr_retired,
  output logic                illegal_instr
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_TRAP      = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [31:0]       r_instr;
  logic [WIDTH-1:0]  r_pc;
  logic [WIDTH-1:0]  w_pc_nxt;
  logic [6:0]        r_opcode;
  logic [2:0]        r_funct3;
  logic [6:0]        r_funct7;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [11:0]       r_imm;
  logic [4:0]        r_shamt;
  logic              r_taken;
  logic              r_imem_req;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic              r_reg_we;
  logic              r_retired;
  logic              r_illegal;
  logic              w_is_mem;
  logic              w_writes_rd;
  logic signed [12:0] w_boff;
  logic signed [20:0] w_joff;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] sext13(input logic signed [12:0] v);
    return WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] sext21(input logic signed [20:0] v);
    return WIDTH'(v);
  endfunction

  assign w_is_mem    = (r_opcode == OP_LOAD) || (r_opcode == OP_STORE);
  assign w_writes_rd = ((r_opcode == OP_R) || (r_opcode == OP_I) ||
                        (r_opcode == OP_LOAD) || (r_opcode == OP_JAL)) && (r_rd != 5'd0);

  // Branch offset is rebuilt from the registered S-form immediate and rd fields.
  assign w_boff = {r_imm[11], r_rd[0], r_imm[10:5], r_rd[4:1], 1'b0};
  assign w_joff = {r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:     if (r_imem_req && bus.imem_ack) w_state_nxt = S_DECODE;
      S_DECODE:    w_state_nxt = is_legal(r_instr[6:0]) ? S_EXECUTE : S_TRAP;
      S_EXECUTE:   w_state_nxt = w_is_mem ? S_MEMORY : S_WRITEBACK;
      S_MEMORY:    if (bus.dmem_ready) w_state_nxt = S_WRITEBACK;
      S_WRITEBACK: w_state_nxt = S_FETCH;
      default:     w_state_nxt = S_TRAP;
    endcase
  end

  always_comb begin
    w_pc_nxt = r_pc + WIDTH'(4);
    if ((r_opcode == OP_BRANCH) && r_taken) w_pc_nxt = r_pc + sext13(w_boff);
    else if (r_opcode == OP_JAL)            w_pc_nxt = r_pc + sext21(w_joff);
  end

  // Raw instruction holding register; only consumed in DECODE and WRITEBACK.
  always_ff @(posedge clk) begin
    if ((r_state == S_FETCH) && (w_state_nxt == S_DECODE)) r_instr <= bus.imem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7   <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_imm      <= '0;
      r_shamt    <= '0;
      r_taken    <= 1'b0;
      r_imem_req <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_reg_we   <= 1'b0;
      r_retired  <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_imem_req <= (w_state_nxt == S_FETCH);
      r_mem_rd   <= (w_state_nxt == S_MEMORY) && (r_opcode == OP_LOAD);
      r_mem_wr   <= (w_state_nxt == S_MEMORY) && (r_opcode == OP_STORE);
      r_reg_we   <= (w_state_nxt == S_WRITEBACK) && w_writes_rd;
      r_retired  <= (w_state_nxt == S_WRITEBACK);
      r_illegal  <= (w_state_nxt == S_TRAP);
      if (r_state == S_DECODE) begin
        r_opcode <= r_instr[6:0];
        r_rd     <= r_instr[11:7];
        r_funct3 <= r_instr[14:12];
        r_rs1    <= r_instr[19:15];
        r_rs2    <= r_instr[24:20];
        r_funct7 <= r_instr[31:25];
        r_shamt  <= r_instr[24:20];
        if ((r_instr[6:0] == OP_STORE) || (r_instr[6:0] == OP_BRANCH))
          r_imm <= {r_instr[31:25], r_instr[11:7]};
        else
          r_imm <= r_instr[31:20];
      end
      if (r_state == S_EXECUTE)   r_taken <= (r_opcode == OP_BRANCH) && branch_taken;
      if (r_state == S_WRITEBACK) r_pc    <= w_pc_nxt;
    end
  end

  assign bus.imem_req     = r_imem_req;
  assign bus.mem_read_en  = r_mem_rd;
  assign bus.mem_write_en = r_mem_wr;
  assign pc               = r_pc;
  assign opcode           = r_opcode;
  assign funct3           = r_funct3;
  assign funct7           = r_funct7;
  assign rs1              = r_rs1;
  assign rs2              = r_rs2;
  assign rd               = r_rd;
  assign imm_reg          = r_imm;
  assign shamt            = r_shamt;
  assign reg_write_en     = r_reg_we;
  assign instr_retired    = r_retired;
  assign illegal_instr    = r_illegal;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: hand-computed expectations for R/I/LOAD/STORE/
// BRANCH/JAL sequences, PC wrap, the TRAP state and asynchronous reset aborts.
`timescale 1ns/1ps
module tb_core_sequencer;
  logic        clk;
  logic        rst;
  logic        branch_taken;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [11:0] imm_reg;
  logic [4:0]  shamt;
  logic        reg_write_en;
  logic        instr_retired;
  logic        illegal_instr;
  int          n_cmp;
  int          n_err;

  core_sequencer_if bus_if();

  core_sequencer #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus_if),
    .branch_taken  (branch_taken),
    .pc            (pc),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .rs1           (rs1),
    .rs2           (rs2),
    .rd            (rd),
    .imm_reg       (imm_reg),
    .shamt         (shamt),
    .reg_write_en  (reg_write_en),
    .instr_retired (instr_retired),
    .illegal_instr (illegal_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in FETCH and take the acknowledging edge; ends in DECODE.
  task automatic fetch_instr(input logic [31:0] instr);
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = instr;
    tick;
    bus_if.imem_ack   = 1'b0;
    bus_if.imem_rdata = 32'h0;
  endtask

  // Non-memory instruction from FETCH back to FETCH in exactly four cycles.
  task automatic run_alu(input logic [31:0] instr, input logic taken,
                         input logic exp_we, input string tag);
    fetch_instr(instr);
    tick;
    branch_taken = taken;
    tick;
    branch_taken = 1'b0;
    chk({tag, "_we"},  {31'd0, reg_write_en},  {31'd0, exp_we});
    chk({tag, "_ret"}, {31'd0, instr_retired}, 32'd1);
    tick;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    branch_taken = 1'b0;
    bus_if.imem_ack = 1'b0;
    bus_if.imem_rdata = 32'h0;
    bus_if.dmem_ready = 1'b0;
    #2 rst = 1'b0;
    tick;
    tick;
    chk("rst_pc",      pc, 32'h0);
    chk("rst_req",     {31'd0, bus_if.imem_req}, 32'd0);
    chk("rst_ill",     {31'd0, illegal_instr}, 32'd0);
    chk("rst_opcode",  {25'd0, opcode}, 32'd0);
    chk("rst_we",      {31'd0, reg_write_en}, 32'd0);
    chk("rst_ret",     {31'd0, instr_retired}, 32'd0);
    rst = 1'b1;
    chk("rel_req0",    {31'd0, bus_if.imem_req}, 32'd0);
    tick;
    chk("rel_req1",    {31'd0, bus_if.imem_req}, 32'd1);

    // add x3,x1,x2 with stray imem_ack/garbage rdata held after the fetch edge
    bus_if.imem_ack = 1'b1;
    bus_if.imem_rdata = 32'h002081B3;
    tick;
    chk("add_req_dec", {31'd0, bus_if.imem_req}, 32'd0);
    bus_if.imem_rdata = 32'hFFFF_FFFF;
    bus_if.dmem_ready = 1'b1;
    tick;
    chk("add_funct3",  {29'd0, funct3}, 32'd0);
    chk("add_rs1",     {27'd0, rs1}, 32'd1);
    chk("add_rs2",     {27'd0, rs2}, 32'd2);
    chk("add_rd",      {27'd0, rd}, 32'd3);
    chk("add_we_ex",   {31'd0, reg_write_en}, 32'd0);
    tick;
    bus_if.imem_ack = 1'b0;
    bus_if.dmem_ready = 1'b0;
    chk("add_we",      {31'd0, reg_write_en}, 32'd1);
    chk("add_ret",     {31'd0, instr_retired}, 32'd1);
    chk("add_pc_wb",   pc, 32'h0);
    tick;
    chk("add_pc",      pc, 32'h4);
    chk("add_req_f",   {31'd0, bus_if.imem_req}, 32'd1);
    chk("add_ret_off", {31'd0, instr_retired}, 32'd0);

    // lw x3,4(x1) with dmem_ready arriving on the fourth MEMORY cycle
    fetch_instr(32'h0040A183);
    tick;
    chk("lw_imm",      {20'd0, imm_reg}, 32'h004);
    chk("lw_funct3",   {29'd0, funct3}, 32'd2);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("lw_rd_en",  {31'd0, bus_if.mem_read_en}, 32'd1);
      chk("lw_wr_off", {31'd0, bus_if.mem_write_en}, 32'd0);
      bus_if.dmem_ready = (i == 3);
      tick;
    end
    bus_if.dmem_ready = 1'b0;
    chk("lw_rd_drop",  {31'd0, bus_if.mem_read_en}, 32'd0);
    chk("lw_we",       {31'd0, reg_write_en}, 32'd1);
    chk("lw_ret",      {31'd0, instr_retired}, 32'd1);
    tick;
    chk("lw_pc",       pc, 32'h8);

    // sw x2,4(x1) with dmem_ready immediate
    fetch_instr(32'h0020A223);
    tick;
    chk("sw_imm",      {20'd0, imm_reg}, 32'h004);
    tick;
    bus_if.dmem_ready = 1'b1;
    chk("sw_wr_en",    {31'd0, bus_if.mem_write_en}, 32'd1);
    chk("sw_rd_off",   {31'd0, bus_if.mem_read_en}, 32'd0);
    chk("sw_we_mem",   {31'd0, reg_write_en}, 32'd0);
    tick;
    bus_if.dmem_ready = 1'b0;
    chk("sw_wr_drop",  {31'd0, bus_if.mem_write_en}, 32'd0);
    chk("sw_we_wb",    {31'd0, reg_write_en}, 32'd0);
    chk("sw_ret",      {31'd0, instr_retired}, 32'd1);
    tick;
    chk("sw_pc",       pc, 32'hC);

    // NOP (rd=0) retires without a register write
    run_alu(32'h00000013, 1'b0, 1'b0, "nop");
    chk("nop_pc",      pc, 32'h10);

    // beq x1,x2,-8 at 0x10, taken then not taken
    run_alu(32'hFE208CE3, 1'b1, 1'b0, "beq_t");
    chk("beq_t_imm",   {20'd0, imm_reg}, 32'hFF9);
    chk("beq_t_pc",    pc, 32'h08);
    run_alu(32'h00000013, 1'b1, 1'b0, "nop_bt");
    chk("nop_bt_pc",   pc, 32'h0C);
    run_alu(32'h00000013, 1'b0, 1'b0, "nop2");
    chk("nop2_pc",     pc, 32'h10);
    run_alu(32'hFE208CE3, 1'b0, 1'b0, "beq_nt");
    chk("beq_nt_pc",   pc, 32'h14);

    // jal x1,+16 then jal x0,-64 wrapping below zero
    run_alu(32'h010000EF, 1'b0, 1'b1, "jal");
    chk("jal_pc",      pc, 32'h24);
    run_alu(32'hFC1FF06F, 1'b0, 1'b0, "jal_neg");
    chk("jal_neg_pc",  pc, 32'hFFFF_FFE4);

    // Illegal opcode traps and stays trapped
    fetch_instr(32'h0000007F);
    tick;
    chk("trap_ill",    {31'd0, illegal_instr}, 32'd1);
    chk("trap_req",    {31'd0, bus_if.imem_req}, 32'd0);
    chk("trap_pc",     pc, 32'hFFFF_FFE4);
    bus_if.imem_ack = 1'b1;
    bus_if.dmem_ready = 1'b1;
    tick;
    tick;
    tick;
    chk("trap_hold",   {31'd0, illegal_instr}, 32'd1);
    chk("trap_req2",   {31'd0, bus_if.imem_req}, 32'd0);
    chk("trap_ret",    {31'd0, instr_retired}, 32'd0);
    chk("trap_pc2",    pc, 32'hFFFF_FFE4);
    #2 rst = 1'b0;
    #1;
    chk("trap_rst_pc", pc, 32'h0);
    chk("trap_rst_il", {31'd0, illegal_instr}, 32'd0);
    bus_if.imem_ack = 1'b0;
    bus_if.dmem_ready = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    chk("resume_req",  {31'd0, bus_if.imem_req}, 32'd1);

    // Reset asserted during a MEMORY wait
    fetch_instr(32'h0040A183);
    tick;
    tick;
    chk("abort_rd1",   {31'd0, bus_if.mem_read_en}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_rd0",   {31'd0, bus_if.mem_read_en}, 32'd0);
    chk("abort_req",   {31'd0, bus_if.imem_req}, 32'd0);
    chk("abort_rd",    {27'd0, rd}, 32'd0);
    bus_if.dmem_ready = 1'b1;
    tick;
    chk("abort_hold",  {31'd0, bus_if.mem_read_en}, 32'd0);
    rst = 1'b1;
    bus_if.dmem_ready = 1'b0;
    tick;
    chk("abort_req1",  {31'd0, bus_if.imem_req}, 32'd1);
    run_alu(32'h002081B3, 1'b0, 1'b1, "add2");
    chk("add2_pc",     pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
